intersection_phase_scheduler: RTL and testbench
===============================================

// Module: intersection_phase_scheduler
// PURPOSE
//  Schedules green time among N_APP approaches of one intersection. Approach 0 is the highway:
//  it rests green by default. Side approaches 1..N_APP-1 latch car requests and are served
//  round-robin. Every handover runs GREEN -> YELLOW -> ALL_RED. Drives per-approach lamp triplets.
// PARAMETERS
//  N_APP  4    number of approaches (2..4); approach 0 = highway/default
//  G_MIN  80   minimum green, in cycles (>=1)
//  G_MAX  200  maximum green for a side approach, in cycles (G_MIN<=G_MAX<=1023)
//  Y_T    20   yellow duration, in cycles (1..1023)
//  AR_T   2    all-red clearance, in cycles (1..1023)
// PORTS
//  clk          in   1        clock
//  rst_n        in   1        reset: synchronous, active-low
//  car_req      in   N_APP    car present per approach; bit 0 is ignored
//  lights       out  3*N_APP  approach i at [3i+2:3i] = {green,yellow,red}, one-hot
//  green_owner  out  2        approach currently owning the phase
//  phase        out  2        0=GREEN 1=YELLOW 2=ALL_RED
// BEHAVIOUR
//  Reset values: state=GREEN, owner=0, cnt=0, nxt=0, pending=0.
//   Lights: approach 0 = 100; all others = 001. green_owner=0, phase=0.
//  Outputs are Moore-decoded from the state/owner registers. No input-to-output path.
//  Owner lamp: GREEN 100, YELLOW 010, ALL_RED 001. Non-owner lamps are always 001.
//  cnt: 10-bit. It clears on every state change and otherwise increments.
//  pending[i] (i>=1):
//   - set by car_req[i]=1 in any cycle;
//   - cleared on the ALL_RED->GREEN edge that grants approach i. Clear wins over set.
//   - The set is masked while i is the owner.
//   - pending[0] is held at 0.
//  GREEN, owner 0: go to YELLOW when cnt>=G_MIN-1 and |pending. There is no max; highway rests.
//  GREEN, owner k!=0: go to YELLOW when either condition holds:
//   - cnt>=G_MIN-1 and (car_req[k]==0 or |pending), or
//   - cnt==G_MAX-1 (forced).
//  On the GREEN->YELLOW edge, latch nxt:
//   - scan k+1..N_APP-1 for the first pending index (from owner 0, scan 1..N_APP-1);
//   - if none is found, nxt=0.
//   - Requests arriving after this edge do not alter nxt.
//  YELLOW: exactly Y_T cycles (exit when cnt==Y_T-1), then ALL_RED.
//  ALL_RED: exactly AR_T cycles (exit when cnt==AR_T-1). Then owner<=nxt, go to GREEN,
//   clear pending[nxt].
//  Green lengths: at least G_MIN cycles. A side green is at most G_MAX cycles.
//  Fairness: after any side approach, no other side waits more than N_APP-1 side phases.
//  Invariant: at most one approach is non-red in any cycle. The bench checks this every cycle.
//  Reset mid-phase: on the next edge, return to the reset values; pending requests are dropped.
//  Illegal state encoding: recover to GREEN, owner 0, next cycle.
// STRUCTURE
//  Shared package tl_pkg:
//   - lamp encodings LAMP_G=3'b100, LAMP_Y=3'b010, LAMP_R=3'b001;
//   - phase encodings PH_GREEN/PH_YELLOW/PH_ALLRED.
//  Sub-module phase_timer:
//   - 10-bit counter with a synchronous clear;
//   - outputs ge_min, eq_max, eq_y, eq_ar (compare values taken as parameters).
//  Round-robin pick: a combinational function in this module.
// TESTING (N_APP=4, G_MIN=8, G_MAX=20, Y_T=3, AR_T=2)
//  1. Reset, no requests for 100 cycles:
//     -> lights=001_001_001_100, phase=0 throughout.
//  2. car_req[2] pulsed 1 cycle at cycle 3:
//     -> YELLOW at cnt 7 (8 green cycles), 3 yellow, 2 all-red, then owner=2 green.
//     -> car_req[2]=0, so after 8 cycles: yellow, all-red, owner=0.
//  3. car_req[1] held high, nothing else:
//     -> owner 1 green exactly 20 cycles (forced), then back to owner 0.
//  4. car_req[1],[2],[3] pulsed together while owner 0:
//     -> owner sequence 1,2,3,0, each green 8 cycles; pending clears on each grant.
//  5. car_req[3] rises during owner-1 YELLOW, with pending[2]=1:
//     -> nxt stays 2; 3 is served after 2.
//  6. rst_n low for 1 cycle mid-YELLOW of owner 2:
//     -> next cycle all reset values; pending=0.
//  Every test: one-hot lamps; at most one non-red approach; phase durations match params.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared lamp and phase encodings for the intersection controller.
package tl_pkg;

  localparam logic [2:0] LAMP_G = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_R = 3'b001;

  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_ALLRED = 2'd2
  } phase_t;

endpackage

// File: rtl/phase_timer.sv
// Phase-elapsed counter with synchronous clear and terminal compares.
module phase_timer
  import tl_pkg::*;
#(
  parameter int G_MIN = 80,
  parameter int G_MAX = 200,
  parameter int Y_T   = 20,
  parameter int AR_T  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  output logic [9:0] cnt,
  output logic       ge_min,
  output logic       eq_max,
  output logic       eq_y,
  output logic       eq_ar
);

  localparam logic [9:0] MIN_TC = 10'(G_MIN - 1);
  localparam logic [9:0] MAX_TC = 10'(G_MAX - 1);
  localparam logic [9:0] Y_TC   = 10'(Y_T - 1);
  localparam logic [9:0] AR_TC  = 10'(AR_T - 1);

  // Saturate so a long highway rest never wraps back below the minimum-green compare.
  always_ff @(posedge clk) begin
    if (!rst_n || clr)
      cnt <= '0;
    else if (cnt != 10'h3FF)
      cnt <= cnt + 10'd1;
  end

  assign ge_min = (cnt >= MIN_TC);
  assign eq_max = (cnt == MAX_TC);
  assign eq_y   = (cnt == Y_TC);
  assign eq_ar  = (cnt == AR_TC);

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Highway-default traffic phase scheduler with round-robin service of side approaches.
//  state     | meaning
//  PH_GREEN  | owner approach green; highway rests here, side greens bounded by G_MAX
//  PH_YELLOW | owner approach yellow for Y_T cycles
//  PH_ALLRED | every approach red for AR_T cycles, then grant nxt
module intersection_phase_scheduler
  import tl_pkg::*;
#(
  parameter int N_APP = 4,
  parameter int G_MIN = 80,
  parameter int G_MAX = 200,
  parameter int Y_T   = 20,
  parameter int AR_T  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_APP-1:0]     car_req,
  output logic [3*N_APP-1:0]   lights,
  output logic [1:0]           green_owner,
  output logic [1:0]           phase
);

  phase_t           state, state_d;
  logic [1:0]       owner, owner_d;
  logic [1:0]       nxt, nxt_d;
  logic [N_APP-1:0] pending, pending_d;
  logic             leave, grant, timer_clr;
  logic             ge_min, eq_max, eq_y, eq_ar;
  logic [9:0]       cnt;

  function automatic logic [1:0] rr_pick(input logic [1:0] own, input logic [N_APP-1:0] pend);
    logic found;
    rr_pick = 2'd0;
    found   = 1'b0;
    for (int i = 1; i < N_APP; i++) begin
      if (!found && (2'(i) > own) && pend[i]) begin
        rr_pick = 2'(i);
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [3*N_APP-1:0] lamp_vec(input phase_t st, input logic [1:0] own);
    logic [2:0] own_lamp;
    case (st)
      PH_GREEN:  own_lamp = LAMP_G;
      PH_YELLOW: own_lamp = LAMP_Y;
      default:   own_lamp = LAMP_R;
    endcase
    lamp_vec = {N_APP{LAMP_R}};
    for (int i = 0; i < N_APP; i++) begin
      if (own == 2'(i))
        lamp_vec[3*i +: 3] = own_lamp;
    end
  endfunction

  phase_timer #(
    .G_MIN (G_MIN),
    .G_MAX (G_MAX),
    .Y_T   (Y_T),
    .AR_T  (AR_T)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (timer_clr),
    .cnt    (cnt),
    .ge_min (ge_min),
    .eq_max (eq_max),
    .eq_y   (eq_y),
    .eq_ar  (eq_ar)
  );

  always_comb begin
    state_d = state;
    owner_d = owner;
    nxt_d   = nxt;
    leave   = 1'b0;
    grant   = 1'b0;
    case (state)
      PH_GREEN: begin
        if (owner == 2'd0)
          leave = ge_min && (|pending);
        else
          leave = (ge_min && (!car_req[owner] || (|pending))) || eq_max;
        if (leave) begin
          state_d = PH_YELLOW;
          nxt_d   = rr_pick(owner, pending);
        end
      end
      PH_YELLOW: begin
        if (eq_y)
          state_d = PH_ALLRED;
      end
      PH_ALLRED: begin
        if (eq_ar) begin
          state_d = PH_GREEN;
          owner_d = nxt;
          grant   = 1'b1;
        end
      end
      default: begin
        state_d = PH_GREEN;
        owner_d = 2'd0;
      end
    endcase
  end

  // The owner's own request is masked; the grant clear takes priority over a same-cycle set.
  always_comb begin
    pending_d = '0;
    for (int i = 1; i < N_APP; i++)
      pending_d[i] = (pending[i] | (car_req[i] && (owner != 2'(i)))) &
                     ~(grant && (nxt == 2'(i)));
  end

  assign timer_clr = (state_d != state);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= PH_GREEN;
      owner   <= 2'd0;
      nxt     <= 2'd0;
      pending <= '0;
      lights  <= lamp_vec(PH_GREEN, 2'd0);
    end else begin
      state   <= state_d;
      owner   <= owner_d;
      nxt     <= nxt_d;
      pending <= pending_d;
      lights  <= lamp_vec(state_d, owner_d);
    end
  end

  assign green_owner = owner;
  assign phase       = state;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed bench for intersection_phase_scheduler with a per-cycle behavioural reference.
module tb_intersection_phase_scheduler;

  localparam int N_APP = 4;
  localparam int G_MIN = 8;
  localparam int G_MAX = 20;
  localparam int Y_T   = 3;
  localparam int AR_T  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  car_req = '0;
  logic [11:0] lights;
  logic [1:0]  green_owner;
  logic [1:0]  phase;

  int n_cmp = 0;
  int n_bad = 0;

  intersection_phase_scheduler #(
    .N_APP (N_APP), .G_MIN (G_MIN), .G_MAX (G_MAX), .Y_T (Y_T), .AR_T (AR_T)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .car_req     (car_req),
    .lights      (lights),
    .green_owner (green_owner),
    .phase       (phase)
  );

  always #5 clk = ~clk;

  // Reference: which approach holds the phase, what colour, how long it has lasted.
  int m_ph, m_own, m_nxt, m_t;
  bit m_pend [N_APP];
  bit m_valid = 0;
  bit rst_seen = 0;

  always @(posedge clk) begin
    int  new_ph, new_own, new_nxt;
    bit  any, go, grant;
    if (!rst_n) begin
      m_ph = 0; m_own = 0; m_nxt = 0; m_t = 0;
      for (int i = 0; i < N_APP; i++) m_pend[i] = 0;
      m_valid = 1;
      rst_seen = 1;
    end else if (m_valid) begin
      any = 0;
      for (int i = 1; i < N_APP; i++) any |= m_pend[i];
      new_ph = m_ph; new_own = m_own; new_nxt = m_nxt; grant = 0; go = 0;
      if (m_ph == 0) begin
        if (m_own == 0) go = (m_t + 1 >= G_MIN) && any;
        else go = ((m_t + 1 >= G_MIN) && (!car_req[m_own] || any)) || (m_t + 1 == G_MAX);
        if (go) begin
          new_ph = 1;
          new_nxt = 0;
          for (int i = N_APP - 1; i > m_own; i--) if (m_pend[i]) new_nxt = i;
        end
      end else if (m_ph == 1) begin
        if (m_t + 1 == Y_T) new_ph = 2;
      end else begin
        if (m_t + 1 == AR_T) begin new_ph = 0; new_own = m_nxt; grant = 1; end
      end
      for (int i = 1; i < N_APP; i++) begin
        if (car_req[i] && i != m_own) m_pend[i] = 1;
        if (grant && i == m_nxt) m_pend[i] = 0;
      end
      m_t = (new_ph != m_ph) ? 0 : m_t + 1;
      m_ph = new_ph; m_own = new_own; m_nxt = new_nxt;
    end
  end

  function automatic logic [11:0] exp_lights(input int ph, input int own);
    logic [11:0] v;
    for (int i = 0; i < N_APP; i++)
      v[3*i +: 3] = (i != own) ? 3'b001 : (ph == 0) ? 3'b100 : (ph == 1) ? 3'b010 : 3'b001;
    return v;
  endfunction

  int log_own[$];
  int log_len[$];
  int run_len, run_own, run_ph;

  always @(negedge clk) begin
    int nonred;
    bit onehot_ok;
    if (m_valid) begin
      n_cmp++;
      if (lights !== exp_lights(m_ph, m_own) || green_owner !== 2'(m_own) || phase !== 2'(m_ph)) begin
        n_bad++;
        $display("FAIL model_cmp t=%0t: lights=%b owner=%0d phase=%0d, expected lights=%b owner=%0d phase=%0d",
                 $time, lights, green_owner, phase, exp_lights(m_ph, m_own), m_own, m_ph);
      end
      nonred = 0; onehot_ok = 1;
      for (int i = 0; i < N_APP; i++) begin
        if (!$onehot(lights[3*i +: 3])) onehot_ok = 0;
        if (lights[3*i +: 3] != 3'b001) nonred++;
      end
      n_cmp++;
      if (!onehot_ok || nonred > 1) begin
        n_bad++;
        $display("FAIL lamp_invariant t=%0t: lights=%b non_red=%0d, required one-hot and at most 1 non-red",
                 $time, lights, nonred);
      end
      if (rst_seen) begin
        rst_seen = 0;
        run_len = 1; run_own = green_owner; run_ph = phase;
      end else if (phase == 2'(run_ph) && green_owner == 2'(run_own)) begin
        run_len++;
      end else begin
        if (run_ph == 0) begin log_own.push_back(run_own); log_len.push_back(run_len); end
        run_len = 1; run_own = green_owner; run_ph = phase;
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic check_log(input string name, input int n, input int owns[4], input int lens[4]);
    check({name, "_count"}, log_own.size(), n);
    for (int i = 0; i < n && i < log_own.size(); i++) begin
      check($sformatf("%s_owner%0d", name, i), log_own[i], owns[i]);
      check($sformatf("%s_green%0d", name, i), log_len[i], lens[i]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #1 rst_n = 1'b0; car_req = '0;
    @(negedge clk); #1 rst_n = 1'b1;
    log_own.delete(); log_len.delete();
  endtask

  task automatic pulse(input logic [3:0] v);
    car_req = v;
    @(negedge clk); #1 car_req = '0;
  endtask

  task automatic wait_for(input string name, input int ph, input int own, input int budget);
    int k = 0;
    while (k < budget && !(phase == 2'(ph) && green_owner == 2'(own))) begin
      @(negedge clk); k++;
    end
    n_cmp++;
    if (!(phase == 2'(ph) && green_owner == 2'(own))) begin
      n_bad++;
      $display("FAIL %s: phase=%0d owner=%0d after %0d cycles, expected phase=%0d owner=%0d",
               name, phase, green_owner, budget, ph, own);
    end
  endtask

  initial begin
    // 1: highway rests with no requests
    do_reset();
    check("reset_lights", int'(lights), int'(12'b001_001_001_100));
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (c % 25 == 0) begin
        check("idle_lights", int'(lights), int'(12'b001_001_001_100));
        check("idle_phase", int'(phase), 0);
      end
    end
    check_log("idle", 0, '{0, 0, 0, 0}, '{0, 0, 0, 0});

    // 2: single side request, side green ends at minimum
    do_reset();
    repeat (3) @(negedge clk);
    #1 pulse(4'b0100);
    repeat (40) @(negedge clk);
    check_log("single", 2, '{0, 2, 0, 0}, '{8, 8, 0, 0});
    check("single_rest_owner", int'(green_owner), 0);

    // 3: held request forces the side green out at maximum
    do_reset();
    #1 car_req = 4'b0010;
    repeat (35) @(negedge clk);
    #1 car_req = '0;
    repeat (30) @(negedge clk);
    check_log("forced", 2, '{0, 1, 0, 0}, '{8, 20, 0, 0});
    check("forced_rest_phase", int'(phase), 0);

    // 4: all sides together are served in order 1,2,3 then highway
    do_reset();
    repeat (2) @(negedge clk);
    #1 pulse(4'b1110);
    repeat (70) @(negedge clk);
    check_log("rr", 4, '{0, 1, 2, 3}, '{8, 8, 8, 8});
    check("rr_rest_owner", int'(green_owner), 0);

    // 5: a request during owner-1 yellow does not displace the latched next owner
    do_reset();
    repeat (2) @(negedge clk);
    #1 pulse(4'b0110);
    wait_for("wait_y1", 1, 1, 60);
    #1 pulse(4'b1000);
    repeat (60) @(negedge clk);
    check_log("late", 4, '{0, 1, 2, 3}, '{8, 8, 8, 8});

    // 6: reset in the middle of owner-2 yellow drops pending work
    do_reset();
    repeat (2) @(negedge clk);
    #1 pulse(4'b1100);
    wait_for("wait_y2", 1, 2, 60);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("midrst_lights", int'(lights), int'(12'b001_001_001_100));
    check("midrst_owner", int'(green_owner), 0);
    check("midrst_phase", int'(phase), 0);
    #1 rst_n = 1'b1;
    log_own.delete(); log_len.delete();
    repeat (40) @(negedge clk);
    check_log("midrst", 0, '{0, 0, 0, 0}, '{0, 0, 0, 0});
    check("midrst_rest_phase", int'(phase), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
